sha256_round_ctrl: RTL and testbench

Sequencing controller and round engine for SHA-256 block compression. It accepts one 512-bit padded message block and expands the message schedule on the fly in a 16-word sliding window. It runs the 64 compression rounds against an internal K-constant ROM, adds the result into the chaining state, and presents the 256-bit digest on a valid/ready handshake. The block feeds the miner's nonce-search loop and supports multi-block chaining.

---
 rtl/sha256_round_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_sha256_round_ctrl.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha256_round_ctrl.sv
// sha256_round_ctrl: SHA-256 block compression engine with sequencing FSM.
// Takes one 512-bit padded block, expands the message schedule on the fly
// in a 16-word sliding window, and runs the 64 rounds at ROUNDS_PER_CYCLE
// rounds per clock (1, 2 or 4). It then folds the result into the chaining
// state and presents the digest.
// Optional macro SHA256_MIDSTATE_EN adds in_midstate/in_use_mid so a
// precomputed chaining value can be loaded on accept.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. A producer holds valid (and its data) until that edge. A
// consumer may raise or lower ready freely. in_ready is high only in IDLE,
// and out_valid is high only in DONE, so blocks never overlap.
//
// Word packing: word 0 (W0 / H0) occupies the most significant 32 bits of
// in_block / out_digest / in_midstate.
module sha256_round_ctrl #(
  parameter int ROUNDS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [511:0] in_block,
  input  logic         in_first,
`ifdef SHA256_MIDSTATE_EN
  input  logic [255:0] in_midstate,
  input  logic         in_use_mid,
`endif
  output logic         out_valid,
  input  logic         out_ready,
  output logic [255:0] out_digest,
  output logic         busy,
  output logic [6:0]   round_idx
);

  localparam int R  = ROUNDS_PER_CYCLE;
  localparam int RW = 32 * R;
  localparam logic [6:0] R_STEP    = 7'(R);
  localparam logic [6:0] LAST_STEP = 7'(64 - R);

  generate
    if (R != 1 && R != 2 && R != 4) begin : g_bad_rounds
      $error("sha256_round_ctrl: ROUNDS_PER_CYCLE must be 1, 2 or 4");
    end
  endgenerate

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ROUND = 2'd1;
  localparam logic [1:0] S_FINAL = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [255:0] IV = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

  localparam logic [31:0] K_ROM [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  // FIPS 180-4 round and schedule functions, rotations written as slices.
  function automatic logic [31:0] big_sig0(input logic [31:0] x);
    return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
  endfunction

  function automatic logic [31:0] big_sig1(input logic [31:0] x);
    return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
  endfunction

  function automatic logic [31:0] sml_sig0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
  endfunction

  function automatic logic [31:0] sml_sig1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
  endfunction

  // Extend the window by R new schedule words and drop the R oldest.
  // New words may depend on words produced earlier in the same step.
  function automatic logic [511:0] shift_window(input logic [511:0] win);
    logic [31:0]  e [20];
    logic [511:0] res;
    for (int i = 0; i < 16; i++) e[i] = win[511 - 32*i -: 32];
    for (int k = 0; k < 4; k++)
      e[16 + k] = sml_sig1(e[14 + k]) + e[9 + k] + sml_sig0(e[1 + k]) + e[k];
    res = '0;
    for (int j = 0; j < 16; j++) res[511 - 32*j -: 32] = e[j + R];
    return res;
  endfunction

  // Apply R consecutive compression rounds starting at round t0.
  function automatic logic [255:0] do_rounds(input logic [255:0] st,
                                             input logic [511:0] win,
                                             input logic [6:0]   t0);
    logic [31:0] a, b, c, d, e, f, g, h, t1, t2, w, kc;
    {a, b, c, d, e, f, g, h} = st;
    for (int k = 0; k < R; k++) begin
      w  = win[511 - 32*k -: 32];
      kc = K_ROM[t0[5:0] + 6'(k)];
      t1 = h + big_sig1(e) + ((e & f) ^ (~e & g)) + kc + w;
      t2 = big_sig0(a) + ((a & b) ^ (a & c) ^ (b & c));
      h = g; g = f; f = e; e = d + t1;
      d = c; c = b; b = a; a = t1 + t2;
    end
    return {a, b, c, d, e, f, g, h};
  endfunction

  logic [1:0]   state;
  logic [255:0] h_reg;     // chaining value H0..H7
  logic [255:0] work;      // working variables a..h
  logic [511:0] win;       // schedule window, slot 0 in the top word
  logic [255:0] h_sum;
  logic [255:0] work_next;
  logic [511:0] win_next;

  // Word-wise mod-2^32 sum of chaining value and working variables.
  always_comb begin
    h_sum = '0;
    for (int i = 0; i < 8; i++)
      h_sum[255 - 32*i -: 32] = h_reg[255 - 32*i -: 32] + work[255 - 32*i -: 32];
  end

  // Next round state and next schedule window.
  always_comb begin
    work_next = do_rounds(work, win, round_idx);
    win_next  = shift_window(win);
  end

  // Status outputs decoded straight from the FSM state.
  always_comb begin
    in_ready  = (state == S_IDLE);
    out_valid = (state == S_DONE);
    busy      = (state == S_ROUND) || (state == S_FINAL);
  end

  // Sequencing FSM and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      h_reg      <= IV;
      work       <= '0;
      win        <= '0;
      round_idx  <= '0;
      out_digest <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            win       <= in_block;
            round_idx <= '0;
            state     <= S_ROUND;
`ifdef SHA256_MIDSTATE_EN
            if (in_use_mid) begin
              work  <= in_midstate;
              h_reg <= in_midstate;
            end else
`endif
            if (in_first) begin
              work  <= IV;
              h_reg <= IV;
            end else begin
              work  <= h_reg;
            end
          end
        end
        S_ROUND: begin
          work      <= work_next;
          win       <= win_next;
          round_idx <= round_idx + R_STEP;
          if (round_idx == LAST_STEP) state <= S_FINAL;
        end
        S_FINAL: begin
          h_reg      <= h_sum;
          out_digest <= h_sum;
          state      <= S_DONE;
        end
        S_DONE: begin
          if (out_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_round_ctrl.sv
// tb_sha256_round_ctrl: directed bench for sha256_round_ctrl using known
// SHA-256 vectors. Three instances cover ROUNDS_PER_CYCLE = 1, 2 and 4.
// Define SHA256_MIDSTATE_EN to also exercise the midstate load path.
module tb_sha256_round_ctrl;

  localparam logic [511:0] ABC_BLK   = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [511:0] EMPTY_BLK = {32'h80000000, 480'h0};
  localparam logic [511:0] TWO_B1 = {
    32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
    32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
    32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
    32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
  localparam logic [511:0] TWO_B2 = {480'h0, 32'h000001c0};
  localparam logic [255:0] ABC_DIG   = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
  localparam logic [255:0] EMPTY_DIG = 256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;
  localparam logic [255:0] TWO_DIG   = 256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;
  localparam logic [255:0] TWO_MID   = 256'h85e655d6_417a1795_3363376a_624cde5c_76e09589_cac5f811_cc4b32c1_f20e533a;

  logic         clk;
  logic         rst_n;
  logic         in_valid, in_ready, in_first, out_valid, out_ready, busy;
  logic [511:0] in_block;
  logic [255:0] out_digest;
  logic [6:0]   round_idx;
  logic [255:0] in_midstate;
  logic         in_use_mid;

  logic         v2, r2, ov2, b2, v4, r4, ov4, b4;
  logic [255:0] dg2, dg4;
  logic [6:0]   ri2, ri4;

  int compared;
  int mismatched;

  // Clock and reset defaults.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  sha256_round_ctrl #(.ROUNDS_PER_CYCLE(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_block(in_block), .in_first(in_first),
`ifdef SHA256_MIDSTATE_EN
    .in_midstate(in_midstate), .in_use_mid(in_use_mid),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .out_digest(out_digest),
    .busy(busy), .round_idx(round_idx));

  sha256_round_ctrl #(.ROUNDS_PER_CYCLE(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(v2), .in_ready(r2),
    .in_block(in_block), .in_first(in_first),
`ifdef SHA256_MIDSTATE_EN
    .in_midstate(in_midstate), .in_use_mid(in_use_mid),
`endif
    .out_valid(ov2), .out_ready(1'b1), .out_digest(dg2),
    .busy(b2), .round_idx(ri2));

  sha256_round_ctrl #(.ROUNDS_PER_CYCLE(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(v4), .in_ready(r4),
    .in_block(in_block), .in_first(in_first),
`ifdef SHA256_MIDSTATE_EN
    .in_midstate(in_midstate), .in_use_mid(in_use_mid),
`endif
    .out_valid(ov4), .out_ready(1'b1), .out_digest(dg4),
    .busy(b4), .round_idx(ri4));

  // Driver: offer one block at a negedge; the next posedge is the accept edge.
  task automatic accept(input logic [511:0] blk, input logic first);
    compared++;
    if (in_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL accept_ready: got %b expected 1", in_ready);
    end
    in_block = blk;
    in_first = first;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    in_block = {16{32'hdeadbeef}};
    in_first = ~first;
  endtask

  // Driver: wait (bounded) for out_valid; lat counts edges since accept.
  task automatic wait_valid(input int start, output int lat, output logic [255:0] dig);
    lat = start;
    while (out_valid !== 1'b1 && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    dig = out_digest;
    compared++;
    if (out_valid !== 1'b1) begin
      mismatched++;
      $display("FAIL wait_valid_timeout: out_valid got %b expected 1 within 200 edges", out_valid);
    end
  endtask

  task automatic run_block(input logic [511:0] blk, input logic first,
                           output int lat, output logic [255:0] dig);
    accept(blk, first);
    wait_valid(0, lat, dig);
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst_n = 1'b0; in_valid = 1'b0; in_block = '0; in_first = 1'b0;
    out_ready = 1'b1; in_midstate = '0; in_use_mid = 1'b0; v2 = 1'b0; v4 = 1'b0;
    repeat (2) @(negedge clk);
    compared += 5;
    if (in_ready !== 1'b1) begin mismatched++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    if (out_valid !== 1'b0) begin mismatched++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    if (busy !== 1'b0) begin mismatched++; $display("FAIL reset_busy: got %b expected 0", busy); end
    if (round_idx !== 7'd0) begin mismatched++; $display("FAIL reset_round_idx: got %0d expected 0", round_idx); end
    if (out_digest !== 256'h0) begin mismatched++; $display("FAIL reset_digest: got %h expected 0", out_digest); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_abc;
    int lat;
    logic [255:0] dig;
    accept(ABC_BLK, 1'b1);
    compared++;
    if (busy !== 1'b1) begin mismatched++; $display("FAIL abc_busy: got %b expected 1", busy); end
    wait_valid(0, lat, dig);
    compared += 4;
    if (lat != 65) begin mismatched++; $display("FAIL abc_latency: got %0d expected 65", lat); end
    if (dig !== ABC_DIG) begin mismatched++; $display("FAIL abc_digest: got %h expected %h", dig, ABC_DIG); end
    if (round_idx !== 7'd64) begin mismatched++; $display("FAIL abc_round_idx: got %0d expected 64", round_idx); end
    if (busy !== 1'b0) begin mismatched++; $display("FAIL abc_busy_done: got %b expected 0", busy); end
    @(negedge clk);
    compared += 2;
    if (out_valid !== 1'b0) begin mismatched++; $display("FAIL abc_handshake_valid: got %b expected 0", out_valid); end
    if (in_ready !== 1'b1) begin mismatched++; $display("FAIL abc_handshake_ready: got %b expected 1", in_ready); end
  endtask

  task automatic test_empty;
    int lat;
    logic [255:0] dig;
    run_block(EMPTY_BLK, 1'b1, lat, dig);
    compared++;
    if (dig !== EMPTY_DIG) begin mismatched++; $display("FAIL empty_digest: got %h expected %h", dig, EMPTY_DIG); end
  endtask

  task automatic test_two_block;
    int lat;
    logic [255:0] dig;
    run_block(TWO_B1, 1'b1, lat, dig);
    compared++;
    if (dig !== TWO_MID) begin mismatched++; $display("FAIL two_block1_digest: got %h expected %h", dig, TWO_MID); end
    run_block(TWO_B2, 1'b0, lat, dig);
    compared++;
    if (dig !== TWO_DIG) begin mismatched++; $display("FAIL two_block2_digest: got %h expected %h", dig, TWO_DIG); end
  endtask

  task automatic test_backpressure;
    int lat;
    logic [255:0] dig;
    out_ready = 1'b0;
    accept(ABC_BLK, 1'b1);
    for (int i = 0; i < 20; i++) begin
      in_valid = i[0];
      in_block = {16{32'h0badf00d}} ^ 512'(i);
      in_first = i[1];
      @(negedge clk);
      compared++;
      if (in_ready !== 1'b0) begin mismatched++; $display("FAIL busy_in_ready: cycle %0d got %b expected 0", i, in_ready); end
    end
    in_valid = 1'b0;
    wait_valid(20, lat, dig);
    compared += 2;
    if (lat != 65) begin mismatched++; $display("FAIL bp_latency: got %0d expected 65", lat); end
    if (dig !== ABC_DIG) begin mismatched++; $display("FAIL bp_digest: got %h expected %h", dig, ABC_DIG); end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      compared++;
      if (out_valid !== 1'b1 || out_digest !== ABC_DIG || in_ready !== 1'b0) begin
        mismatched++;
        $display("FAIL bp_hold: cycle %0d valid=%b ready=%b digest=%h expected valid=1 ready=0 digest=%h",
                 i, out_valid, in_ready, out_digest, ABC_DIG);
      end
    end
    out_ready = 1'b1;
    @(negedge clk);
    compared += 2;
    if (out_valid !== 1'b0) begin mismatched++; $display("FAIL bp_release_valid: got %b expected 0", out_valid); end
    if (in_ready !== 1'b1) begin mismatched++; $display("FAIL bp_release_ready: got %b expected 1", in_ready); end
  endtask

  task automatic test_midreset;
    int lat;
    int n;
    logic [255:0] dig;
    accept(TWO_B2, 1'b0);
    n = 0;
    while (round_idx !== 7'd30 && n < 100) begin
      @(negedge clk);
      n++;
    end
    compared++;
    if (round_idx !== 7'd30) begin mismatched++; $display("FAIL midreset_reach30: got %0d expected 30", round_idx); end
    rst_n = 1'b0;
    #1;
    compared += 5;
    if (in_ready !== 1'b1) begin mismatched++; $display("FAIL midreset_in_ready: got %b expected 1", in_ready); end
    if (out_valid !== 1'b0) begin mismatched++; $display("FAIL midreset_out_valid: got %b expected 0", out_valid); end
    if (busy !== 1'b0) begin mismatched++; $display("FAIL midreset_busy: got %b expected 0", busy); end
    if (round_idx !== 7'd0) begin mismatched++; $display("FAIL midreset_round_idx: got %0d expected 0", round_idx); end
    if (out_digest !== 256'h0) begin mismatched++; $display("FAIL midreset_digest: got %h expected 0", out_digest); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_block(ABC_BLK, 1'b0, lat, dig);
    compared += 2;
    if (lat != 65) begin mismatched++; $display("FAIL rerun_latency: got %0d expected 65", lat); end
    if (dig !== ABC_DIG) begin mismatched++; $display("FAIL rerun_digest: got %h expected %h", dig, ABC_DIG); end
  endtask

  task automatic test_unrolled;
    int n;
    int lat2;
    int lat4;
    logic [255:0] d2, d4;
    compared += 2;
    if (r2 !== 1'b1) begin mismatched++; $display("FAIL r2_ready: got %b expected 1", r2); end
    if (r4 !== 1'b1) begin mismatched++; $display("FAIL r4_ready: got %b expected 1", r4); end
    in_block = ABC_BLK;
    in_first = 1'b1;
    v2 = 1'b1;
    v4 = 1'b1;
    @(negedge clk);
    v2 = 1'b0;
    v4 = 1'b0;
    in_block = {16{32'h12345678}};
    n = 0; lat2 = -1; lat4 = -1; d2 = '0; d4 = '0;
    while (n < 200 && (lat2 < 0 || lat4 < 0)) begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        compared += 2;
        if (ri2 !== 7'd2) begin mismatched++; $display("FAIL r2_step: got %0d expected 2", ri2); end
        if (ri4 !== 7'd4) begin mismatched++; $display("FAIL r4_step: got %0d expected 4", ri4); end
      end
      if (ov2 === 1'b1 && lat2 < 0) begin lat2 = n; d2 = dg2; end
      if (ov4 === 1'b1 && lat4 < 0) begin lat4 = n; d4 = dg4; end
    end
    compared += 4;
    if (lat2 != 33) begin mismatched++; $display("FAIL r2_latency: got %0d expected 33", lat2); end
    if (lat4 != 17) begin mismatched++; $display("FAIL r4_latency: got %0d expected 17", lat4); end
    if (d2 !== ABC_DIG) begin mismatched++; $display("FAIL r2_digest: got %h expected %h", d2, ABC_DIG); end
    if (d4 !== ABC_DIG) begin mismatched++; $display("FAIL r4_digest: got %h expected %h", d4, ABC_DIG); end
    @(negedge clk);
  endtask

`ifdef SHA256_MIDSTATE_EN
  task automatic test_midstate;
    int lat;
    logic [255:0] dig;
    in_use_mid = 1'b0;
    run_block(TWO_B1, 1'b1, lat, dig);
    in_midstate = dig;
    in_use_mid = 1'b1;
    accept(TWO_B2, 1'b1);
    in_use_mid = 1'b0;
    in_midstate = '0;
    wait_valid(0, lat, dig);
    @(negedge clk);
    compared++;
    if (dig !== TWO_DIG) begin mismatched++; $display("FAIL midstate_digest: got %h expected %h", dig, TWO_DIG); end
  endtask
`endif

  // Test sequence and final report.
  initial begin
    compared = 0;
    mismatched = 0;
    test_reset();
    test_abc();
    test_empty();
    test_two_block();
    test_backpressure();
    test_midreset();
    test_unrolled();
`ifdef SHA256_MIDSTATE_EN
    test_midstate();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
